// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_if
// Brief    : Lock input and staged reset outputs of the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if;
    logic       locked_in;
    logic       reset_ram;
    logic       reset_pipe;
    logic       reset_disp;
    logic       ready;
    logic [7:0] lock_loss_count;

    // Master supplies the lock indication and consumes the staged resets
    modport master (
        output locked_in,
        input  reset_ram,
        input  reset_pipe,
        input  reset_disp,
        input  ready,
        input  lock_loss_count
    );

    modport slave (
        input  locked_in,
        output reset_ram,
        output reset_pipe,
        output reset_disp,
        output ready,
        output lock_loss_count
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Qualifies DCM lock, then releases RAM, pipeline and display
//            resets in strict order; any lock loss re-asserts all of them.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int CNT_WIDTH          = 16
) (
    input  wire logic         clock,
    input  wire logic         reset,
    reset_sequencer_if.slave  seq
);

    typedef enum logic [5:0] {
        S_WAIT_LOCK = 6'b000001,
        S_STABLE    = 6'b000010,
        S_REL_RAM   = 6'b000100,
        S_REL_PIPE  = 6'b001000,
        S_REL_DISP  = 6'b010000,
        S_RUN       = 6'b100000
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_stable_last = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_gap_last    = CNT_WIDTH'(STAGE_GAP - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_sync;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_next_cnt;
    logic                   w_lock_lost;

    logic                   r_reset_ram;
    logic                   r_reset_pipe;
    logic                   r_reset_disp;
    logic                   r_ready;
    logic [7:0]             r_lock_loss_count;
    logic                   w_reset_ram;
    logic                   w_reset_pipe;
    logic                   w_reset_disp;
    logic                   w_ready;

    assign w_locked_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], seq.locked_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= S_WAIT_LOCK;
            r_cnt             <= '0;
            r_reset_ram       <= 1'b1;
            r_reset_pipe      <= 1'b1;
            r_reset_disp      <= 1'b1;
            r_ready           <= 1'b0;
            r_lock_loss_count <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_reset_ram  <= w_reset_ram;
            r_reset_pipe <= w_reset_pipe;
            r_reset_disp <= w_reset_disp;
            r_ready      <= w_ready;
            if (w_lock_lost && (r_lock_loss_count != 8'hFF)) begin
                r_lock_loss_count <= r_lock_loss_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_lock_lost  = 1'b0;

        case (r_state)
            S_WAIT_LOCK: begin
                if (w_locked_sync) begin
                    w_next_state = S_STABLE;
                end
            end
            S_STABLE: begin
                if (r_cnt == c_stable_last) begin
                    w_next_state = S_REL_RAM;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            S_REL_RAM, S_REL_PIPE, S_REL_DISP: begin
                if (r_cnt == c_gap_last) begin
                    case (r_state)
                        S_REL_RAM:  w_next_state = S_REL_PIPE;
                        S_REL_PIPE: w_next_state = S_REL_DISP;
                        default:    w_next_state = S_RUN;
                    endcase
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                w_next_state = S_RUN;
            end
            default: begin
                w_next_state = S_WAIT_LOCK;
            end
        endcase

        // Lock loss overrides every other transition, including terminal counts
        if (!w_locked_sync && (r_state != S_WAIT_LOCK)) begin
            w_next_state = S_WAIT_LOCK;
            w_next_cnt   = '0;
            w_lock_lost  = 1'b1;
        end
    end

    always_comb begin
        w_reset_ram  = 1'b1;
        w_reset_pipe = 1'b1;
        w_reset_disp = 1'b1;
        w_ready      = 1'b0;
        case (w_next_state)
            S_REL_RAM: begin
                w_reset_ram = 1'b0;
            end
            S_REL_PIPE: begin
                w_reset_ram  = 1'b0;
                w_reset_pipe = 1'b0;
            end
            S_REL_DISP: begin
                w_reset_ram  = 1'b0;
                w_reset_pipe = 1'b0;
                w_reset_disp = 1'b0;
            end
            S_RUN: begin
                w_reset_ram  = 1'b0;
                w_reset_pipe = 1'b0;
                w_reset_disp = 1'b0;
                w_ready      = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign seq.reset_ram       = r_reset_ram;
    assign seq.reset_pipe      = r_reset_pipe;
    assign seq.reset_disp      = r_reset_disp;
    assign seq.ready           = r_ready;
    assign seq.lock_loss_count = r_lock_loss_count;

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on locked_in, legal range 2..4.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive locked cycles required before the first release, legal range ≥1.
REQ-003 SHALL have parameter STAGE_GAP, default 16: cycles between successive reset releases, legal range ≥1.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the internal counter; LOCK_STABLE_CYCLES and STAGE_GAP SHALL both be < 2^CNT_WIDTH.
REQ-005 SHALL have port clock, input, 1 bit: single clock, 50 MHz fpga clock from the DCM/BUFG; all flops on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high user reset, already debounced.
REQ-007 SHALL have port locked_in, input, 1 bit: DCM lock indication (locked_ram), asynchronous to clock.
REQ-008 SHALL have port reset_ram, output, 1 bit: active-high reset for the ZBT RAM controllers.
REQ-009 SHALL have port reset_pipe, output, 1 bit: active-high reset for the processing pipeline.
REQ-010 SHALL have port reset_disp, output, 1 bit: active-high reset for the display/VGA logic.
REQ-011 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port lock_loss_count, output, 8 bits: saturating count of lock-loss events.

Function
REQ-013 SHALL pass locked_in through a SYNC_STAGES-deep flop chain; locked_sync (the last flop) SHALL be the only lock signal used internally.
REQ-014 SHALL implement states WAIT_LOCK, STABLE, REL_RAM, REL_PIPE, REL_DISP, RUN.
REQ-015 SHALL register all outputs and update them on the same edge the state changes (no combinational outputs).
REQ-016 SHALL drive the outputs per state as follows: WAIT_LOCK/STABLE = all three resets 1; REL_RAM = reset_ram 0 only; REL_PIPE = reset_ram 0 and reset_pipe 0; REL_DISP = all three resets 0; RUN = all three resets 0 and ready 1. ready SHALL be 0 in every state except RUN.
REQ-017 SHALL transition WAIT_LOCK→STABLE, with counter cleared to 0, on the edge where locked_sync=1.
REQ-018 SHALL increment the counter each cycle in STABLE, and SHALL enter REL_RAM, with counter cleared, on the edge where counter==LOCK_STABLE_CYCLES-1 and locked_sync=1.
REQ-019 SHALL, in REL_RAM, REL_PIPE and REL_DISP, count STAGE_GAP cycles, then advance to the next state (REL_PIPE, REL_DISP, RUN respectively) with counter cleared.
REQ-020 SHALL remain in RUN indefinitely while locked_sync=1.
REQ-021 SHALL, in any state other than WAIT_LOCK, go to WAIT_LOCK on the edge locked_sync=0 is seen, asserting all resets and clearing ready and the counter on that edge; this has priority over every other transition.
REQ-022 SHALL increment lock_loss_count on each REQ-021 event, saturating at 255; there SHALL be no wrap.
REQ-023 SHALL, on re-lock after a loss, repeat the full sequence, including the full LOCK_STABLE_CYCLES qualification.
REQ-024 SHALL hold the counter at CNT_WIDTH bits; it SHALL never wrap, because the terminal compares bound it.
REQ-025 SHALL keep release order strict: reset_disp SHALL never be 0 while reset_pipe=1, and reset_pipe SHALL never be 0 while reset_ram=1, in any cycle.

Reset
REQ-026 SHALL, when reset=1 at a rising edge and regardless of state: set state=WAIT_LOCK, counter=0, all synchronizer flops=0, reset_ram/reset_pipe/reset_disp=1, ready=0, lock_loss_count=0; reset SHALL have priority over lock events.
REQ-027 SHALL, after reset deasserts with locked_in steadily 1, restart the sequence from synchronization, with the full REQ-028 latency.

Verification (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_GAP=4)
REQ-028 Bench SHALL cover basic release: reset, then locked_in 0→1 sampled at edge 1 -> reset_ram 0 after edge 11, reset_pipe 0 after edge 15, reset_disp 0 after edge 19, ready 1 after edge 23.
REQ-029 Bench SHALL cover a lock glitch during qualification: locked_in high 5 cycles then low 1 cycle -> outputs stay asserted, lock_loss_count=1, and the full 8-cycle qualification restarts after re-lock.
REQ-030 Bench SHALL cover lock loss in RUN: locked_in falls, sampled at edge m -> all resets 1 and ready 0 after edge m+2, lock_loss_count increments by 1.
REQ-031 Bench SHALL cover reset mid-sequence: reset=1 for one cycle while in REL_PIPE -> next cycle all resets 1, lock_loss_count 0, then full sequence replays with timing identical to REQ-028 relative to reset deassert.
REQ-032 Bench SHALL cover saturation: 300 lock-loss events -> lock_loss_count holds at 255.
REQ-033 Bench SHALL check the REQ-025 ordering and the one-hot-state invariant on every cycle of all the above scenarios.
